// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - instruction-fetch initiator driving the instruction ROM and the IF/ID register
//
// Purpose:
//   Owns the program counter and issues one ROM fetch at a time. Each returned
//   instruction is registered together with its PC into the IF/ID output stage
//   through a valid/stall handshake. Branch redirects and pipeline flushes
//   restart the fetch at a new PC and discard any stale response.
//
// Ports:
//   clk, rst         clock (rising edge) and asynchronous active-high reset
//   stall            downstream cannot accept; held output stays stable
//   branch_flag      redirect pulse from ID, target on branch_target
//   flush            pipeline flush pulse, target on new_pc
//   rom_ce, rom_addr fetch request towards the ROM (registered, addr == pc)
//   rom_inst,rom_ack ROM response and its valid qualifier
//   if_pc, if_inst   instruction and its PC for IF/ID
//   if_valid         if_pc/if_inst hold a live instruction
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        flush,
  input  logic [31:0] new_pc,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        rom_ack,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam logic [31:0] STEP = 32'(PC_STEP);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        ce_q, ce_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;

  logic consume;
  logic accept;

  // The held instruction leaves on any edge where downstream is not stalling.
  assign consume = if_valid_q && !stall;
  // A response can only be taken if the output register is free or draining.
  assign accept  = (state_q == WAIT) && rom_ack && (!if_valid_q || !stall);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;

    if (flush) begin
      pc_d       = new_pc;
      state_d    = REQ;
      if_valid_d = 1'b0;
    end else if (branch_flag) begin
      // The response for the old address is dropped, but the output register
      // keeps its delay-slot instruction and still drains normally.
      pc_d    = branch_target;
      state_d = REQ;
      if (consume) begin
        if_valid_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ:  state_d = WAIT;
        WAIT: begin
          if (accept) begin
            if_inst_d  = rom_inst;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + STEP;
            state_d    = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
      if (!accept && consume) begin
        if_valid_d = 1'b0;
      end
    end
  end

  // rom_ce is registered from the next state so it lines up with rom_addr.
  assign ce_d = (state_d != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ce_q       <= 1'b0;
      if_pc_q    <= 32'h0;
      if_inst_q  <= 32'h0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ce_q       <= ce_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign rom_ce   = ce_q;
  assign rom_addr = pc_q;
  assign if_pc    = if_pc_q;
  assign if_inst  = if_inst_q;
  assign if_valid = if_valid_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - directed self-checking bench for inst_fetch_ctrl
module tb_inst_fetch_ctrl;

  localparam logic [31:0] K = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = 32'h0;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst = 32'h0;
  logic        rom_ack = 1'b1;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int checks = 0;
  int errs   = 0;

  inst_fetch_ctrl #(.RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .flush(flush), .new_pc(new_pc),
    .rom_ce(rom_ce), .rom_addr(rom_addr),
    .rom_inst(rom_inst), .rom_ack(rom_ack),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  // Responder: samples ce/addr at the edge, data valid the following cycle.
  always @(posedge clk) begin
    if (rom_ce) rom_inst <= rom_addr ^ K;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ce", {31'b0, rom_ce}, 32'd0);
    chk("rst_addr", rom_addr, 32'h0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("c0_idle_ce", {31'b0, rom_ce}, 32'd0);
    tick(); // cycle 1
    chk("c1_ce", {31'b0, rom_ce}, 32'd1);
    chk("c1_addr", rom_addr, 32'h0);
    tick(); // cycle 2
    chk("c2_valid", {31'b0, if_valid}, 32'd0);
    tick(); // cycle 3
    chk("c3_valid", {31'b0, if_valid}, 32'd1);
    chk("c3_pc", if_pc, 32'h0);
    chk("c3_inst", if_inst, 32'hA5A5A5A5);
    chk("c3_addr", rom_addr, 32'h4);
    rom_ack = 1'b0;
    tick(); // cycle 4
    chk("c4_valid", {31'b0, if_valid}, 32'd0);
    tick(); // cycle 5
    chk("c5_addr", rom_addr, 32'h4);
    tick(); // cycle 6
    chk("c6_addr", rom_addr, 32'h4);
    tick(); // cycle 7
    chk("c7_addr", rom_addr, 32'h4);
    chk("c7_ce", {31'b0, rom_ce}, 32'd1);
    chk("c7_valid", {31'b0, if_valid}, 32'd0);
    rom_ack = 1'b1;
    tick(); // cycle 8
    chk("c8_valid", {31'b0, if_valid}, 32'd1);
    chk("c8_pc", if_pc, 32'h4);
    chk("c8_inst", if_inst, 32'hA5A5A5A1);
    chk("c8_addr", rom_addr, 32'h8);
    tick(); // cycle 9
    chk("c9_valid", {31'b0, if_valid}, 32'd0);
    tick(); // cycle 10
    chk("c10_pc", if_pc, 32'h8);
    chk("c10_inst", if_inst, 32'hA5A5A5AD);
    stall = 1'b1;
    repeat (4) tick(); // cycles 11..14
    chk("c14_pc", if_pc, 32'h8);
    chk("c14_inst", if_inst, 32'hA5A5A5AD);
    chk("c14_valid", {31'b0, if_valid}, 32'd1);
    chk("c14_ce", {31'b0, rom_ce}, 32'd1);
    chk("c14_addr", rom_addr, 32'hC);
    tick(); // cycle 15
    stall = 1'b0;
    chk("c15_pc", if_pc, 32'h8);
    tick(); // cycle 16
    chk("c16_pc", if_pc, 32'hC);
    chk("c16_inst", if_inst, 32'hA5A5A5A9);
    chk("c16_valid", {31'b0, if_valid}, 32'd1);
    stall = 1'b1;
    tick(); // cycle 17
    chk("c17_addr", rom_addr, 32'h10);
    branch_flag = 1'b1;
    branch_target = 32'h100;
    tick(); // cycle 18
    branch_flag = 1'b0;
    chk("c18_addr", rom_addr, 32'h100);
    chk("c18_slot_pc", if_pc, 32'hC);
    chk("c18_slot_valid", {31'b0, if_valid}, 32'd1);
    stall = 1'b0;
    tick(); // cycle 19
    chk("c19_valid", {31'b0, if_valid}, 32'd0);
    tick(); // cycle 20
    chk("c20_pc", if_pc, 32'h100);
    chk("c20_inst", if_inst, 32'hA5A5A4A5);
    tick(); // cycle 21
    flush = 1'b1;
    new_pc = 32'h20;
    branch_flag = 1'b1;
    branch_target = 32'h100;
    tick(); // cycle 22
    flush = 1'b0;
    branch_flag = 1'b0;
    chk("c22_valid", {31'b0, if_valid}, 32'd0);
    chk("c22_addr", rom_addr, 32'h20);
    tick(); // cycle 23
    chk("c23_valid", {31'b0, if_valid}, 32'd0);
    tick(); // cycle 24
    chk("c24_pc", if_pc, 32'h20);
    chk("c24_inst", if_inst, 32'hA5A5A585);
    tick(); // cycle 25
    flush = 1'b1;
    new_pc = 32'hFFFF_FFFC;
    tick(); // cycle 26
    flush = 1'b0;
    chk("c26_addr", rom_addr, 32'hFFFF_FFFC);
    tick(); // cycle 27
    tick(); // cycle 28
    chk("c28_pc", if_pc, 32'hFFFF_FFFC);
    chk("c28_inst", if_inst, 32'h5A5A5A59);
    chk("c28_wrap_addr", rom_addr, 32'h0);
    stall = 1'b1;
    tick(); // cycle 29 (WAIT at 0, output held)
    chk("c29_valid", {31'b0, if_valid}, 32'd1);
    chk("c29_ce", {31'b0, rom_ce}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_ce", {31'b0, rom_ce}, 32'd0);
    chk("arst_valid", {31'b0, if_valid}, 32'd0);
    chk("arst_pc", if_pc, 32'h0);
    chk("arst_addr", rom_addr, 32'h0);
    stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_idle_ce", {31'b0, rom_ce}, 32'd0);
    tick();
    chk("rel_req_ce", {31'b0, rom_ce}, 32'd1);
    chk("rel_req_addr", rom_addr, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule
